ladybird_mem_arbiter: RTL

- Round-robin arbiter that shares one MMU-style request/response port between N_PORTS requesters, for example instruction fetch, data access, or several ladybird cores.
- It grants the downstream request channel to one requester at a time.
- It records the grantee ID of every accepted request in an in-order ID FIFO, and routes each downstream response back to the requester that issued it.
- It sits between the requesters and the MMU/AXI front end.

---
 rtl/ladybird_mem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ladybird_mem_arbiter.sv
// Round-robin arbiter that shares one request/response memory port between N_PORTS requesters.
// An in-order ID FIFO records each accepted request and steers its response back to the requester that issued it.
module ladybird_mem_arbiter #(
  parameter int N_PORTS         = 2,
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic [N_PORTS-1:0]                 s_valid,
  output logic [N_PORTS-1:0]                 s_ready,
  input  logic [N_PORTS*XLEN-1:0]            s_addr,
  input  logic [N_PORTS*XLEN-1:0]            s_data,
  input  logic [N_PORTS-1:0]                 s_we,
  input  logic [N_PORTS*3-1:0]               s_funct,
  output logic [N_PORTS-1:0]                 s_rvalid,
  input  logic [N_PORTS-1:0]                 s_rready,
  output logic [XLEN-1:0]                    s_rdata,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [XLEN-1:0]                    m_addr,
  output logic [XLEN-1:0]                    m_data,
  output logic                               m_we,
  output logic [2:0]                         m_funct,
  input  logic                               m_rvalid,
  output logic                               m_rready,
  input  logic [XLEN-1:0]                    m_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                               err
);

  localparam int IDW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int AW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Handshake rules: a request transfers when m_valid & m_ready (the grantee
  // sees the same event as s_valid & s_ready); a response transfers when
  // m_rvalid & m_rready (the head requester sees s_rvalid & s_rready).

  logic [IDW-1:0] prio_q;
  logic           locked_q;
  logic [IDW-1:0] lock_idx_q;
  logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           err_q;

  logic [IDW-1:0] rr_idx;
  logic           rr_found;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] grantee;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] head;
  logic           full;
  logic           empty;
  logic           grant_valid;
  logic           push;
  logic           pop;
  logic           stray_rsp;
  logic           lock_drop;

  // Search upward from the priority pointer, wrapping, for the first valid requester.
  always_comb begin
    rr_idx   = prio_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      cand = IDW'((int'(prio_q) + k) % N_PORTS);
      if (!rr_found && s_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign full        = (count_q == CW'(MAX_OUTSTANDING));
  assign empty       = (count_q == '0);
  assign grantee     = locked_q ? lock_idx_q : rr_idx;
  // Gating with nrst keeps every output quiet while reset is held.
  assign grant_valid = s_valid[grantee] & ~full & nrst;
  assign push        = grant_valid & m_ready;
  assign lock_drop   = locked_q & ~s_valid[lock_idx_q];

  assign sel     = grant_valid ? grantee : '0;
  assign m_valid = grant_valid;
  assign m_addr  = s_addr[sel*XLEN +: XLEN];
  assign m_data  = s_data[sel*XLEN +: XLEN];
  assign m_we    = s_we[sel];
  assign m_funct = s_funct[sel*3 +: 3];

  always_comb begin
    s_ready = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      s_ready[i] = push && (grantee == IDW'(i));
    end
  end

  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    s_rvalid = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      s_rvalid[i] = nrst && !empty && m_rvalid && (head == IDW'(i));
    end
  end

  // With nothing outstanding a response is swallowed so the downstream side cannot stall.
  assign s_rdata   = m_rdata;
  assign m_rready  = nrst & (empty | s_rready[head]);
  assign pop       = m_rvalid & m_rready & ~empty;
  assign stray_rsp = m_rvalid & empty;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prio_q     <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        prio_q   <= (grantee == IDW'(N_PORTS - 1)) ? '0 : grantee + IDW'(1);
        wr_ptr_q <= (wr_ptr_q == AW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == AW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CW'(1);
      end

      // Hold the grantee across a stall so m_* stay stable until the handshake.
      if (push) begin
        locked_q <= 1'b0;
      end else if (grant_valid && !m_ready) begin
        locked_q   <= 1'b1;
        lock_idx_q <= grantee;
      end else if (lock_drop) begin
        locked_q <= 1'b0;
      end

      if (lock_drop || stray_rsp) begin
        err_q <= 1'b1;
      end
    end
  end

  // The ID storage needs no reset: entries are only read once pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= grantee;
    end
  end

  assign outstanding = count_q;
  assign err         = err_q;

endmodule
